stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/stopwatch_bcd_digit.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared types and constants for the stopwatch controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int c_PRESC_W            = 30;
    localparam int c_DEFAULT_TICK_PERIOD = 50_000_000;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
`ifdef STOPWATCH_CTRL_LAP_EN
        ,
        ST_LAP   = 2'd3
`endif
    } sw_state_t;

endpackage

`default_nettype wire

// File: rtl/stopwatch_bcd_digit.sv
// ============================================================================
//  Module   : stopwatch_bcd_digit
//  Purpose  : Modulo-DIGIT_LIMIT counter with enable, sync clear and carry.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int DIGIT_LIMIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [3:0] o_value,
    output logic       o_carry
);

    // A modulus above ten would expose non-BCD nibbles, so it is capped.
    localparam int   c_LIMIT = (DIGIT_LIMIT > 10) ? 10 : DIGIT_LIMIT;
    localparam bcd_t c_LAST  = bcd_t'(c_LIMIT - 1);

    bcd_t r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= (r_value == c_LAST) ? '0 : r_value + 4'd1;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_en & (r_value == c_LAST);

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Two-digit BCD stopwatch with run/pause/clear and optional lap
//             freeze (compiled in with macro STOPWATCH_CTRL_LAP_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_PERIOD = c_DEFAULT_TICK_PERIOD,
    parameter int DIGIT_LIMIT = 10
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       BTN_START_STOP,
    input  logic       BTN_CLEAR,
    input  logic       BTN_LAP,
    output logic [7:0] LED,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       CARRY_OUT
);

    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_PERIOD - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);

    sw_state_t              r_state;
    sw_state_t              w_next_state;
    logic                   r_arm;
    logic                   r_ss_q;
    logic                   r_clr_q;
    logic                   w_clr_edge;
    logic                   w_ss_edge;
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   w_counting;
    logic                   w_tick;
    logic [3:0]             w_units;
    logic [3:0]             w_tens;
    logic                   w_units_carry;
    logic                   w_tens_carry;
    logic                   r_carry;

    // r_arm blocks edges on the first cycle after reset, so levels held
    // through reset release are absorbed into the _q registers first.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_arm   <= 1'b0;
            r_ss_q  <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_arm   <= 1'b1;
            r_ss_q  <= BTN_START_STOP;
            r_clr_q <= BTN_CLEAR;
        end
    end

    assign w_clr_edge = r_arm & BTN_CLEAR & ~r_clr_q;
    assign w_ss_edge  = r_arm & BTN_START_STOP & ~r_ss_q & ~w_clr_edge;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic       r_lap_q;
    logic       w_lap_edge;
    logic [7:0] r_lap_latch;

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_lap_q <= 1'b0;
        end else begin
            r_lap_q <= BTN_LAP;
        end
    end

    assign w_lap_edge = r_arm & BTN_LAP & ~r_lap_q & ~w_clr_edge &
                        ~(BTN_START_STOP & ~r_ss_q);

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_lap_latch <= 8'h00;
        end else if (w_clr_edge) begin
            r_lap_latch <= 8'h00;
        end else if (r_state == ST_RUN && w_lap_edge) begin
            r_lap_latch <= {w_tens, w_units};
        end
    end

    assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign LED        = LAP_ACTIVE ? r_lap_latch : {w_tens, w_units};
`else
    logic w_unused_lap;
    assign w_unused_lap = BTN_LAP;
    assign w_counting   = (r_state == ST_RUN);
    assign LED          = {w_tens, w_units};
`endif

    assign w_tick = w_counting && (r_presc == c_TICK_LAST);

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
        end else if (w_clr_edge) begin
            r_presc <= '0;
        end else if (w_counting) begin
            r_presc <= w_tick ? '0 : r_presc + c_PRESC_ONE;
        end
    end

    stopwatch_bcd_digit #(.DIGIT_LIMIT(DIGIT_LIMIT)) u_units (
        .clk     (CLK_50M),
        .rst     (RST),
        .i_en    (w_tick),
        .i_clr   (w_clr_edge),
        .o_value (w_units),
        .o_carry (w_units_carry)
    );

    stopwatch_bcd_digit #(.DIGIT_LIMIT(DIGIT_LIMIT)) u_tens (
        .clk     (CLK_50M),
        .rst     (RST),
        .i_en    (w_tick & w_units_carry),
        .i_clr   (w_clr_edge),
        .o_value (w_tens),
        .o_carry (w_tens_carry)
    );

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_tens_carry & ~w_clr_edge;
        end
    end

    assign CARRY_OUT = r_carry;

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_clr_edge) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_ss_edge) w_next_state = ST_RUN;
                ST_RUN: begin
                    if (w_ss_edge) w_next_state = ST_PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
                    else if (w_lap_edge) w_next_state = ST_LAP;
`endif
                end
                ST_PAUSE: if (w_ss_edge) w_next_state = ST_RUN;
`ifdef STOPWATCH_CTRL_LAP_EN
                ST_LAP: begin
                    if (w_ss_edge) w_next_state = ST_PAUSE;
                    else if (w_lap_edge) w_next_state = ST_RUN;
                end
`endif
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RUNNING    = 1'b0;
        LAP_ACTIVE = 1'b0;
        case (r_state)
            ST_RUN:  RUNNING = 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
            ST_LAP: begin
                RUNNING    = 1'b1;
                LAP_ACTIVE = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Self-checking bench for stopwatch_ctrl with TICK_PERIOD = 4.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int TP = 4;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       bss  = 1'b0;
    logic       bclr = 1'b0;
    logic       blap = 1'b0;
    logic [7:0] led;
    logic       running;
    logic       lap_active;
    logic       carry;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    stopwatch_ctrl #(.TICK_PERIOD(TP), .DIGIT_LIMIT(10)) dut (
        .CLK_50M        (clk),
        .RST            (rst),
        .BTN_START_STOP (bss),
        .BTN_CLEAR      (bclr),
        .BTN_LAP        (blap),
        .LED            (led),
        .RUNNING        (running),
        .LAP_ACTIVE     (lap_active),
        .CARRY_OUT      (carry)
    );

    always #5 clk = ~clk;

    // Behavioural model: count as a decimal integer 0..99, elapsed cycles per tick.
    int m_mode  = M_IDLE;
    int m_count = 0;
    int m_presc = 0;
    int m_latch = 0;
    bit m_carry = 1'b0;
    bit m_armed = 1'b0;
    bit m_pss = 1'b0, m_pclr = 1'b0, m_plap = 1'b0;
    bit e_clr, e_ss, e_lap, m_tick, m_counting;
    int old_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_presc = 0; m_latch = 0;
            m_carry = 1'b0; m_armed = 1'b0;
            m_pss = 1'b0; m_pclr = 1'b0; m_plap = 1'b0;
        end else begin
            e_clr = m_armed && bclr && !m_pclr;
            e_ss  = m_armed && bss && !m_pss && !e_clr;
            e_lap = LAP_EN && m_armed && blap && !m_plap && !e_clr && !(bss && !m_pss);
            m_counting = (m_mode == M_RUN) || (m_mode == M_LAP);
            m_tick  = m_counting && (m_presc == TP - 1);
            m_carry = 1'b0;
            old_count = m_count;
            if (e_clr) begin
                m_mode = M_IDLE; m_count = 0; m_presc = 0; m_latch = 0;
            end else begin
                if (m_counting) m_presc = m_tick ? 0 : m_presc + 1;
                if (m_tick) begin
                    m_carry = (m_count == 99);
                    m_count = (m_count + 1) % 100;
                end
                if (e_ss) begin
                    if (m_mode == M_RUN || m_mode == M_LAP) m_mode = M_PAUSE;
                    else m_mode = M_RUN;
                end else if (e_lap) begin
                    if (m_mode == M_RUN) begin
                        m_mode = M_LAP;
                        m_latch = old_count;
                    end else if (m_mode == M_LAP) begin
                        m_mode = M_RUN;
                    end
                end
            end
            m_pss = bss; m_pclr = bclr; m_plap = blap;
            m_armed = 1'b1;
        end
    end

    function automatic logic [7:0] exp_led();
        int v;
        v = (m_mode == M_LAP) ? m_latch : m_count;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_led",     led,                  exp_led());
            check("model_running", {7'd0, running},      {7'd0, (m_mode == M_RUN || m_mode == M_LAP)});
            check("model_lap",     {7'd0, lap_active},   {7'd0, (m_mode == M_LAP)});
            check("model_carry",   {7'd0, carry},        {7'd0, m_carry});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bss = 1'b0; bclr = 1'b0; blap = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic press_ss();
        bss = 1'b1; cyc(1); bss = 1'b0;
    endtask

    task automatic press_lap();
        blap = 1'b1; cyc(1); blap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("reset_led", led, 8'h00);
        check("reset_running", {7'd0, running}, 8'h00);

        // Basic run: ticks every 4 cycles, 40 cycles -> 10.
        do_reset();
        press_ss();
        cyc(3);  check("run_before_tick", led, 8'h00);
        cyc(1);  check("run_first_tick",  led, 8'h01);
        cyc(36); check("run_40", led, 8'h10);
        check("run_running", {7'd0, running}, 8'h01);

        // Pause mid-prescaler keeps the fractional second.
        do_reset();
        press_ss();
        cyc(29); check("pause_at_07", led, 8'h07);
        press_ss();
        cyc(20); check("paused_hold", led, 8'h07);
        check("paused_running", {7'd0, running}, 8'h00);
        press_ss(); check("resume_0", led, 8'h07);
        cyc(1);     check("resume_1", led, 8'h07);
        cyc(1);     check("resume_tick", led, 8'h08);

        // 99 -> 00 wrap with carry pulse.
        do_reset();
        press_ss();
        cyc(396); check("wrap_99", led, 8'h99);
        cyc(3);   check("wrap_pre_carry", {7'd0, carry}, 8'h00);
        cyc(1);   check("wrap_00", led, 8'h00);
        check("wrap_carry", {7'd0, carry}, 8'h01);
        cyc(1);   check("wrap_carry_end", {7'd0, carry}, 8'h00);

        // Lap freeze at 23.
        do_reset();
        press_ss();
        cyc(92); check("lap_23", led, 8'h23);
        press_lap();
        check("lap_active", {7'd0, lap_active}, {7'd0, LAP_EN});
        cyc(12); check("lap_frozen", led, LAP_EN ? 8'h23 : 8'h26);
        press_lap();
        check("lap_release", led, 8'h26);
        check("lap_inactive", {7'd0, lap_active}, 8'h00);
        check("lap_running", {7'd0, running}, 8'h01);

        // CLEAR beats START_STOP in the same cycle.
        do_reset();
        press_ss();
        cyc(180); check("clr_45", led, 8'h45);
        bss = 1'b1; bclr = 1'b1;
        cyc(1);
        bss = 1'b0; bclr = 1'b0;
        check("clr_led", led, 8'h00);
        check("clr_running", {7'd0, running}, 8'h00);
        cyc(8);   check("clr_stays", led, 8'h00);

        // Reset mid-count with START_STOP held through release.
        do_reset();
        press_ss();
        cyc(126); check("rst_31", led, 8'h31);
        bss = 1'b1;
        #2 rst = 1'b1;
        #1 check("rst_async_led", led, 8'h00);
        cyc(2);
        rst = 1'b0;
        cyc(10);
        check("rst_held_led", led, 8'h00);
        check("rst_held_idle", {7'd0, running}, 8'h00);
        bss = 1'b0;
        cyc(2);  check("rst_released_idle", {7'd0, running}, 8'h00);
        press_ss();
        check("rst_repress_run", {7'd0, running}, 8'h01);
        cyc(4);  check("rst_repress_tick", led, 8'h01);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
